// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-write store buffer with byte-wise store-to-load forwarding
// Optional STORE_BUF_COALESCE_EN: a store to the youngest entry's word merges into that entry.
module dmem_store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  core_addr,
  input  logic [31:0]      core_wdata,
  input  logic [3:0]       core_wstrb,
  input  logic             core_we,
  input  logic             core_re,
  output logic [31:0]      core_rdata,
  output logic [XLEN-1:0]  mem_raddr,
  input  logic [31:0]      mem_rdata,
  output logic             mem_wvalid,
  input  logic             mem_wready,
  output logic [XLEN-1:0]  mem_waddr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  output logic [CNT_W-1:0] buf_count,
  output logic             buf_empty,
  output logic             buf_full,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int AW    = XLEN - 2;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [3:0]       strb_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             do_push;
  logic             do_pop;
  logic             do_merge;
  logic             do_alloc;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^core_addr[1:0];

  assign buf_count  = count_q;
  assign buf_empty  = (count_q == '0);
  assign buf_full   = (count_q == CNT_W'(DEPTH));
  assign overflow   = overflow_q;

  assign mem_wvalid = !buf_empty;
  assign mem_waddr  = {addr_q[head_q], 2'b00};
  assign mem_wdata  = data_q[head_q];
  assign mem_wstrb  = strb_q[head_q];
  assign mem_raddr  = {core_addr[XLEN-1:2], 2'b00};

  assign do_push = core_we && (core_wstrb != 4'b0000);
  assign do_pop  = mem_wvalid && mem_wready;

`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0] yidx;
  assign yidx = tail_q - PTR_W'(1);
  // A lone head that is draining this cycle cannot absorb the store: memory takes its old bytes.
  assign do_merge = do_push && !buf_empty &&
                    (addr_q[yidx] == core_addr[XLEN-1:2]) &&
                    !(do_pop && (count_q == CNT_W'(1)));
`else
  assign do_merge = 1'b0;
`endif

  // A full buffer still accepts a store when the head leaves in the same cycle.
  assign do_alloc = do_push && !do_merge && (!buf_full || do_pop);

  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;

    if (do_pop) begin
      head_d = head_q + PTR_W'(1);
    end

`ifdef STORE_BUF_COALESCE_EN
    if (do_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (core_wstrb[b]) begin
          data_d[yidx][8*b +: 8] = core_wdata[8*b +: 8];
        end
      end
      strb_d[yidx] = strb_q[yidx] | core_wstrb;
    end
`endif

    if (do_alloc) begin
      addr_d[tail_q] = core_addr[XLEN-1:2];
      data_d[tail_q] = core_wdata;
      strb_d[tail_q] = core_wstrb;
      tail_d         = tail_q + PTR_W'(1);
    end

    if (do_push && !do_merge && buf_full && !do_pop) begin
      overflow_d = 1'b1;
    end

    count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    strb_q <= strb_d;
  end

  // Walk oldest to youngest so later matches override earlier ones per lane.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = head_q;
    core_rdata = mem_rdata;
    if (core_re) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (addr_q[idx] == core_addr[XLEN-1:2])) begin
          for (int b = 0; b < 4; b++) begin
            if (strb_q[idx][b]) begin
              core_rdata[8*b +: 8] = data_q[idx][8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - randomized bench for dmem_store_buffer against a queue-based model
module tb_dmem_store_buffer;

`ifdef STORE_BUF_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic        core_we;
  logic        core_re;
  logic [31:0] core_rdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  buf_count;
  logic        buf_empty;
  logic        buf_full;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;

  dmem_store_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_wstrb(core_wstrb),
    .core_we(core_we), .core_re(core_re), .core_rdata(core_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .buf_count(buf_count), .buf_empty(buf_empty), .buf_full(buf_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [31:0] mrd);
    logic [31:0] r;
    r = mrd;
    for (int b = 0; b < 4; b++) begin
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (q[j].a == addr[31:2] && q[j].s[b]) begin
          r[8*b +: 8] = q[j].d[8*b +: 8];
          break;
        end
      end
    end
    return r;
  endfunction

  // Drives one cycle, checks the pre-edge outputs, then advances the model to the post-edge state.
  task automatic step(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic wready, input logic [31:0] mrd);
    bit   push, pop, full, merge;
    ent_t e;
    @(negedge clk);
    core_we = we; core_re = re; core_addr = addr; core_wdata = wdata;
    core_wstrb = wstrb; mem_wready = wready; mem_rdata = mrd;
    #1;
    check("count", buf_count, q.size());
    check("empty", buf_empty, q.size() == 0);
    check("full", buf_full, q.size() == DEPTH);
    check("wvalid", mem_wvalid, q.size() != 0);
    check("overflow", overflow, m_ovf);
    check("raddr", mem_raddr, {addr[31:2], 2'b00});
    check("rdata", core_rdata, re ? model_load(addr, mrd) : mrd);
    if (q.size() != 0) begin
      check("waddr", mem_waddr, {q[0].a, 2'b00});
      check("wdata", mem_wdata, q[0].d);
      check("wstrb", mem_wstrb, q[0].s);
    end
    push  = we && (wstrb != 0);
    pop   = (q.size() != 0) && wready;
    full  = (q.size() == DEPTH);
    merge = COAL && push && q.size() != 0 && q[$].a == addr[31:2] && !(pop && q.size() == 1);
    if (merge) begin
      e = q[$];
      for (int b = 0; b < 4; b++) if (wstrb[b]) e.d[8*b +: 8] = wdata[8*b +: 8];
      e.s = e.s | wstrb;
      q[$] = e;
    end
    if (pop) void'(q.pop_front());
    if (push && !merge) begin
      if (full && !pop) m_ovf = 1'b1;
      else begin
        e.a = addr[31:2]; e.d = wdata; e.s = wstrb;
        q.push_back(e);
      end
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic wready);
    step(1'b1, 1'b0, addr, wdata, wstrb, wready, $urandom);
  endtask

  task automatic idle(input logic wready);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, wready, $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; core_we = 1'b0; core_re = 1'b0; mem_wready = 1'($urandom);
    @(negedge clk);
    rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; core_addr = '0; core_wdata = '0; core_wstrb = '0;
    core_we = 1'b0; core_re = 1'b0; mem_rdata = '0; mem_wready = 1'b0;
    m_ovf = 1'b0;
    do_reset();
    check("rst_empty", buf_empty, 1'b1);
    check("rst_full", buf_full, 1'b0);
    check("rst_count", buf_count, 3'd0);
    check("rst_wvalid", mem_wvalid, 1'b0);
    check("rst_ovf", overflow, 1'b0);

    store(32'h100, 32'hDEADBEEF, 4'hF, 1'b1);
    idle(1'b1);
    check("single_wvalid", mem_wvalid, 1'b1);
    check("single_waddr", mem_waddr, 32'h100);
    check("single_wdata", mem_wdata, 32'hDEADBEEF);
    idle(1'b1);
    check("single_empty", buf_empty, 1'b1);

    store(32'h200, 32'h000000AA, 4'h1, 1'b0);
    step(1'b0, 1'b1, 32'h200, 32'h0, 4'h0, 1'b0, 32'h11223344);
    check("fwd_merge", core_rdata, 32'h112233AA);
    repeat (2) idle(1'b1);

    store(32'h300, 32'h11111111, 4'hF, 1'b0);
    store(32'h300, 32'h22222222, 4'h3, 1'b0);
    step(1'b0, 1'b1, 32'h302, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);
    check("youngest_wins", core_rdata, 32'h11112222);
    check("youngest_count", buf_count, COAL ? 3'd1 : 3'd2);
    repeat (3) idle(1'b1);

    for (int k = 0; k < 5; k++) store(32'h500 + 32'(4 * k), 32'hA0 + 32'(k), 4'hF, 1'b0);
    idle(1'b0);
    check("ovf_full", buf_full, 1'b1);
    check("ovf_set", overflow, 1'b1);
    check("ovf_count", buf_count, 3'd4);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      check("ovf_drain_order", mem_waddr, 32'h500 + 32'(4 * k));
    end
    idle(1'b1);
    check("ovf_drained", buf_empty, 1'b1);
    do_reset();

    for (int k = 0; k < 4; k++) store(32'h600 + 32'(4 * k), 32'hB0 + 32'(k), 4'hF, 1'b0);
    store(32'h400, 32'h0000C0DE, 4'hF, 1'b1);
    idle(1'b0);
    check("pushpop_count", buf_count, 3'd4);
    check("pushpop_ovf", overflow, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      check("pushpop_order", mem_waddr, (k == 3) ? 32'h400 : 32'h604 + 32'(4 * k));
    end
    idle(1'b1);

    for (int k = 0; k < 3; k++) store(32'h700 + 32'(4 * k), 32'(k), 4'hF, 1'b0);
    do_reset();
    check("midrst_wvalid", mem_wvalid, 1'b0);
    check("midrst_count", buf_count, 3'd0);
    check("midrst_ovf", overflow, 1'b0);
    repeat (3) idle(1'b1);

    for (int n = 0; n < 600; n++) begin
      if (n % 97 == 96) do_reset();
      step(($urandom_range(0, 2) != 0), 1'($urandom),
           32'h100 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3)),
           $urandom, 4'($urandom), ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-write buffer between the core's data-memory port and the data RAM/bus.
- Core stores are accepted into a FIFO in the same cycle and drained to memory through a valid/ready write channel.
- Core loads are answered combinationally from the memory read port, byte-merged with any younger buffered stores to the same word (store-to-load forwarding).
- Memory-side write latency therefore never stalls the core's MEM stage, provided the buffer does not overflow.

Parameters:
XLEN, 32, address width.
DEPTH, 4, number of buffer entries; power of two, minimum 2.
CNT_W, $clog2(DEPTH)+1, width of occupancy count.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
core_addr  input  XLEN  byte address from core LSU.
core_wdata  input  32  store data, already lane-aligned.
core_wstrb  input  4  byte strobes.
core_we  input  1  store request this cycle.
core_re  input  1  load request this cycle.
core_rdata  output  32  load data, combinational.
mem_raddr  output  XLEN  word-aligned read address to memory.
mem_rdata  input  32  combinational read data from memory.
mem_wvalid  output  1  head entry valid.
mem_wready  input  1  memory accepts head entry.
mem_waddr  output  XLEN  word-aligned write address of head entry.
mem_wdata  output  32  head entry data.
mem_wstrb  output  4  head entry strobes.
buf_count  output  CNT_W  occupancy.
buf_empty  output  1  count == 0 (also usable as the fence-complete indication).
buf_full  output  1  count == DEPTH.
overflow  output  1  sticky error flag.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - On reset, regardless of in-flight traffic: count=0, head/tail pointers=0, overflow=0, mem_wvalid=0, buf_empty=1, buf_full=0. Entry contents are don't-care.
- Entry format: {word address = core_addr[XLEN-1:2], data[31:0], strb[3:0]}.
  - mem_waddr = {entry address, 2'b00}.
  - mem_raddr = {core_addr[XLEN-1:2], 2'b00}.
- Push: core_we=1 with core_wstrb != 0 enqueues at the tail on the clock edge. The entry is visible to forwarding from the next cycle.
- Drain/pop:
  - mem_wvalid = !buf_empty.
  - Pop occurs on mem_wvalid && mem_wready.
  - Head fields stay stable while mem_wvalid=1 and mem_wready=0.
- Simultaneous push and pop:
  - Count is unchanged.
  - Legal when full: the pushed entry takes the freed slot.
- Overflow:
  - Condition: push while full with no pop in the same cycle.
  - The store is dropped, buffer contents are unchanged, and overflow is set to 1.
  - overflow is cleared only by rst.
- Pointer arithmetic: pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Load forwarding (core_re=1):
  - Each byte lane i is taken from the youngest valid entry with a matching word address and strb[i]=1.
  - Lanes with no such entry take mem_rdata[8i+7:8i].
  - The head entry being popped this cycle still participates in forwarding, since memory is not yet updated this cycle.
  - If core_re=0, core_rdata = mem_rdata.
- Store and load in the same cycle (core_we and core_re both 1, not produced by the core): the store is pushed, and the load sees only previously buffered entries.
- Ordering: memory writes are issued strictly in push order.

Optional Feature:
Macro STORE_BUF_COALESCE_EN.
- Defined:
  - A push whose word address equals the youngest entry's address merges into that entry. Lanes with core_wstrb[i]=1 overwrite data; entry strb |= core_wstrb. Count is unchanged.
  - No merge when the youngest entry is the head and is popping that cycle. In that case a normal push occurs.
  - A merge while full does not set overflow.
- Undefined: every push allocates a new entry.

Test Plan:
- Single push/drain: rst; store addr 0x100, data 0xDEADBEEF, wstrb 0xF; mem_wready=1 -> next cycle mem_wvalid=1, mem_waddr=0x100; popped that cycle; buf_empty=1 after.
- Forwarding merge: mem_wready=0; store 0x200 data 0x000000AA wstrb 0x1; then load 0x200 with mem_rdata=0x11223344 -> core_rdata=0x112233AA.
- Youngest wins: mem_wready=0; store 0x300 0x11111111 wstrb 0xF, then 0x300 0x22222222 wstrb 0x3; load 0x300 -> 0x11112222. buf_count=2, or 1 with STORE_BUF_COALESCE_EN.
- Full and overflow: mem_wready=0; 5 stores to distinct addresses, DEPTH=4 -> buf_full=1 after 4; 5th sets overflow=1 and buf_count stays 4. Then mem_wready=1 -> the 4 original entries drain in order.
- Push while full with pop: full buffer, mem_wready=1, store 0x400 same cycle -> count stays 4, overflow=0, 0x400 drained last.
- Mid-operation reset: 3 entries buffered, assert rst one cycle -> mem_wvalid=0, buf_count=0, overflow=0 next cycle; no further writes are issued.
